playfield_store: RTL and testbench
==================================

// Module: playfield_store
// PURPOSE
//  Parametrised Tetris playfield memory: holds the COLS x ROWS grid of settled cells.
//  Locks a PIECE x PIECE piece mask at a pixel position and reports collision combinationally.
//  After each lock, an FSM finds full rows and clears them, shifting the rows above down.
//  Sits between the game-control FSM (lock requests) and the VGA drawer (board readout).
// PARAMETERS
//  COLS   10   playfield width in cells
//  ROWS   24   playfield height in cells
//  CELL   20   pixels per cell edge; pixel-to-cell mapping is pos / CELL (truncating)
//  PIECE  4    piece mask edge in cells
// PORTS
//  clk          in   1            system clock, all state on rising edge
//  reset        in   1            asynchronous, active-high; clears all state
//  piece_x_pos  in   10           piece top-left pixel X
//  piece_y_pos  in   10           piece top-left pixel Y
//  piece_mask   in   PIECE*PIECE  bit r*PIECE+c = cell (col+c, row+r)
//  lock_valid   in   1            request to merge piece_mask into board
//  lock_ready   out  1            high only in IDLE; lock accepted when valid && ready
//  collide      out  1            comb: mask overlaps a set cell or lies outside the grid
//  board        out  COLS*ROWS    cell (x,y) at bit y*COLS+x; y=0 is the top row
//  busy         out  1            high from the cycle after accept through DONE
//  clear_done   out  1            one-cycle pulse in DONE
//  lines_cleared out $clog2(PIECE+1)  rows removed by the last lock; valid while clear_done=1
//  lines_total  out  16           running count of cleared rows; saturates at 16'hFFFF
//  top_out      out  1            comb: any cell of row 0 set (game-over flag)
// BEHAVIOUR
//  - Reset: board=0, state=IDLE, lock_ready=1, busy=0, clear_done=0,
//    lines_cleared=0, lines_total=0. Reset mid-clear aborts immediately; no partial shift survives.
//  - col = piece_x_pos/CELL, row = piece_y_pos/CELL, computed in 10-bit width.
//    Cell indices are formed at a width that holds COLS*ROWS without wrap.
//  - collide: per mask bit set, flags if col+c >= COLS, or row+r >= ROWS, or the board cell is 1.
//    Uses the current board, including during busy; no registered delay.
//  - FSM states:
//    IDLE -> SCAN: on accept, the same edge ORs in-grid mask bits into board.
//      Out-of-grid bits are dropped silently. row_ptr=ROWS-1, cnt=0.
//    SCAN: if row row_ptr is all ones -> SHIFT;
//      else if row_ptr==0 -> DONE;
//      else row_ptr-=1. One row per cycle.
//    SHIFT: rows 1..row_ptr take rows 0..row_ptr-1, row 0 := 0, cnt+=1, lines_total+=1 (saturating).
//      Returns to SCAN with row_ptr unchanged, so rows falling into row_ptr are rechecked.
//    DONE: clear_done=1, lines_cleared=cnt, -> IDLE next cycle.
//  - lines_cleared holds its value until the next DONE; it is valid to sample while clear_done=1.
//  - lock_valid outside IDLE: ignored (lock_ready=0); the requester must hold the request.
//  - Latency, no full rows: accept edge + ROWS SCAN cycles + 1 DONE cycle.
//    Each cleared row adds 2 cycles (SHIFT + rescan).
//  - board is registered; the drawer may read it at any time, including mid-clear.
// TESTING
//  1. Reset, then lock mask 16'h000F at (0,460) -> row 23 cols 0-3 set, i.e. board[233:230]=4'hF;
//     clear_done after 25 cycles; lines_cleared=0.
//  2. Pre-fill row 23 cols 0-5 and row 22 col 9, then lock mask 16'h000F at (120,460)
//     -> row 23 cleared, old row 22 moves to row 23 (bit 239=1); lines_cleared=1; lines_total=1.
//  3. Fill rows 20-23 except col 9, then lock mask 16'h1111 at (180,400)
//     -> lines_cleared=4; board==0; SHIFT/SCAN rechecks row 23 each time.
//  4. Mask 16'h000F at (160,0) (cols 8-11) -> collide=1; after lock only cols 8-9 of row 0 set;
//     top_out=1.
//  5. Hold lock_valid during busy -> lock_ready=0 and no second merge until IDLE.
//     Assert reset mid-SHIFT -> board=0 and busy=0 immediately.
//  6. Repeat clears with lines_total preset near 16'hFFFE -> count stops at 16'hFFFF.

Source files
------------

// File: rtl/playfield_store.sv
// Tetris playfield: settled-cell grid with combinational piece collision, piece locking,
// and a scan/shift FSM that removes full rows after every lock.
module playfield_store #(
    parameter int          COLS            = 10,
    parameter int          ROWS            = 24,
    parameter int          CELL            = 20,
    parameter int          PIECE           = 4,
    parameter logic [15:0] LINES_TOTAL_RST = 16'h0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [9:0]                   piece_x_pos,
    input  logic [9:0]                   piece_y_pos,
    input  logic [PIECE*PIECE-1:0]       piece_mask,
    input  logic                         lock_valid,
    output logic                         lock_ready,
    output logic                         collide,
    output logic [COLS*ROWS-1:0]         board,
    output logic                         busy,
    output logic                         clear_done,
    output logic [$clog2(PIECE+1)-1:0]   lines_cleared,
    output logic [15:0]                  lines_total,
    output logic                         top_out
);

    localparam int NB = COLS * ROWS;
    localparam int NM = PIECE * PIECE;
    localparam int IW = $clog2(NB);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(PIECE + 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SHIFT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [NB-1:0]   board_q, board_d;
    logic [RW-1:0]   row_ptr_q, row_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   lines_cleared_q, lines_cleared_d;
    logic [15:0]     lines_total_q, lines_total_d;
    logic            lock_ready_q, lock_ready_d;
    logic            busy_q, busy_d;
    logic            clear_done_q, clear_done_d;

    logic [9:0]      cell_col;
    logic [9:0]      cell_row;
    logic [NM-1:0]   bit_in;
    logic [NM-1:0]   bit_oob;
    logic [NM-1:0]   bit_hit;
    logic [IW-1:0]   bit_idx [NM];
    logic [NB-1:0]   merge_mask;
    logic [ROWS-1:0] row_full;
    logic [NB-1:0]   shifted;

    assign cell_col = piece_x_pos / 10'(CELL);
    assign cell_row = piece_y_pos / 10'(CELL);

    // Per mask bit: grid coordinates at 11 bits so col+c / row+r cannot wrap.
    genvar gi;
    for (gi = 0; gi < NM; gi++) begin : g_bit
        logic [10:0] cc_g;
        logic [10:0] rr_g;
        assign cc_g        = {1'b0, cell_col} + 11'(gi % PIECE);
        assign rr_g        = {1'b0, cell_row} + 11'(gi / PIECE);
        assign bit_in[gi]  = piece_mask[gi] && (cc_g < 11'(COLS)) && (rr_g < 11'(ROWS));
        assign bit_oob[gi] = piece_mask[gi] && !bit_in[gi];
        assign bit_idx[gi] = IW'(32'(rr_g) * COLS + 32'(cc_g));
        assign bit_hit[gi] = bit_in[gi] && board_q[bit_idx[gi]];
    end

    assign collide = |(bit_oob | bit_hit);

    always_comb begin
        merge_mask = '0;
        for (int i = 0; i < NM; i++) begin
            if (bit_in[i]) begin
                merge_mask[bit_idx[i]] = 1'b1;
            end
        end
    end

    // Row y takes row y-1 for y <= row_ptr; row 0 always refills with zeros.
    for (gi = 0; gi < ROWS; gi++) begin : g_row
        assign row_full[gi] = &board_q[gi*COLS +: COLS];
        if (gi == 0) begin : g_top
            assign shifted[0 +: COLS] = '0;
        end else begin : g_below
            assign shifted[gi*COLS +: COLS] = (row_ptr_q >= RW'(gi)) ?
                board_q[(gi-1)*COLS +: COLS] : board_q[gi*COLS +: COLS];
        end
    end

    always_comb begin
        state_d         = state_q;
        board_d         = board_q;
        row_ptr_d       = row_ptr_q;
        cnt_d           = cnt_q;
        lines_cleared_d = lines_cleared_q;
        lines_total_d   = lines_total_q;
        case (state_q)
            S_IDLE: begin
                if (lock_valid && lock_ready_q) begin
                    board_d   = board_q | merge_mask;
                    row_ptr_d = RW'(ROWS - 1);
                    cnt_d     = '0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (row_full[row_ptr_q]) begin
                    state_d = S_SHIFT;
                end else if (row_ptr_q == '0) begin
                    lines_cleared_d = cnt_q;
                    state_d         = S_DONE;
                end else begin
                    row_ptr_d = row_ptr_q - RW'(1);
                end
            end
            S_SHIFT: begin
                board_d       = shifted;
                cnt_d         = cnt_q + CW'(1);
                lines_total_d = (lines_total_q == 16'hFFFF) ? lines_total_q
                                                            : lines_total_q + 16'd1;
                state_d       = S_SCAN;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake/status flags are registered from the next state so they align with it.
    assign lock_ready_d = (state_d == S_IDLE);
    assign busy_d       = (state_d != S_IDLE);
    assign clear_done_d = (state_d == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            board_q         <= '0;
            row_ptr_q       <= '0;
            cnt_q           <= '0;
            lines_cleared_q <= '0;
            lines_total_q   <= LINES_TOTAL_RST;
            lock_ready_q    <= 1'b1;
            busy_q          <= 1'b0;
            clear_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            board_q         <= board_d;
            row_ptr_q       <= row_ptr_d;
            cnt_q           <= cnt_d;
            lines_cleared_q <= lines_cleared_d;
            lines_total_q   <= lines_total_d;
            lock_ready_q    <= lock_ready_d;
            busy_q          <= busy_d;
            clear_done_q    <= clear_done_d;
        end
    end

    assign board         = board_q;
    assign lock_ready    = lock_ready_q;
    assign busy          = busy_q;
    assign clear_done    = clear_done_q;
    assign lines_cleared = lines_cleared_q;
    assign lines_total   = lines_total_q;
    assign top_out       = |board_q[COLS-1:0];

endmodule

// File: tb/tb_playfield_store.sv
// Scoreboard bench for playfield_store: directed locks push expected results, a monitor
// checks them on every clear_done; a second instance starts its line count near saturation.
module tb_playfield_store;

    localparam int NB = 240;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    px, py;
    logic [15:0]   pm;
    logic          lock_valid;

    logic          lock_ready, collide, busy, clear_done, top_out;
    logic [NB-1:0] board;
    logic [2:0]    lines_cleared;
    logic [15:0]   lines_total;

    logic          s_lock_ready, s_collide, s_busy, s_clear_done, s_top_out;
    logic [NB-1:0] s_board;
    logic [2:0]    s_lines_cleared;
    logic [15:0]   s_lines_total;

    playfield_store dut (
        .clk(clk), .reset(reset), .piece_x_pos(px), .piece_y_pos(py), .piece_mask(pm),
        .lock_valid(lock_valid), .lock_ready(lock_ready), .collide(collide), .board(board),
        .busy(busy), .clear_done(clear_done), .lines_cleared(lines_cleared),
        .lines_total(lines_total), .top_out(top_out)
    );

    playfield_store #(.LINES_TOTAL_RST(16'hFFFE)) dut_sat (
        .clk(clk), .reset(reset), .piece_x_pos(px), .piece_y_pos(py), .piece_mask(pm),
        .lock_valid(lock_valid), .lock_ready(s_lock_ready), .collide(s_collide), .board(s_board),
        .busy(s_busy), .clear_done(s_clear_done), .lines_cleared(s_lines_cleared),
        .lines_total(s_lines_total), .top_out(s_top_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NB-1:0] board;
        int            lines;
        int            total;
        int            total_sat;
        int            acc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] rect(input logic [NB-1:0] b, input int x0, input int y0,
                                           input int w, input int h);
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++)
                b[y*10 + x] = 1'b1;
        return b;
    endfunction

    // Monitor: every clear_done pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && clear_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_clear_done: got 1 expected 0");
                end else begin
                    e = sb.pop_front();
                    $display("clear_done: lines_cleared=%0d lines_total=%0h sat_total=%0h latency=%0d",
                             lines_cleared, lines_total, s_lines_total, cyc - e.acc + 1);
                    chk("lines_cleared", 256'(lines_cleared), 256'(e.lines));
                    chk("lines_total", 256'(lines_total), 256'(e.total));
                    chk("sat_lines_total", 256'(s_lines_total), 256'(e.total_sat));
                    chk("board", 256'(board), 256'(e.board));
                    chk("latency", 256'(cyc - e.acc + 1), 256'(25 + 2 * e.lines));
                    chk("sat_clear_done", 256'(s_clear_done), 256'(1));
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!lock_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!lock_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
    endtask

    task automatic lock_req(input logic [9:0] x, input logic [9:0] y, input logic [15:0] m,
                            input logic [NB-1:0] eb, input int el, input int et, input int ets,
                            input bit track);
        exp_t e;
        @(negedge clk);
        px = x; py = y; pm = m; lock_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        lock_valid = 1'b0;
        if (track) begin
            e.board = eb; e.lines = el; e.total = et; e.total_sat = ets; e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic probe(input string name, input logic [9:0] x, input logic [9:0] y,
                         input logic [15:0] m, input logic exp);
        @(negedge clk);
        px = x; py = y; pm = m; lock_valid = 1'b0;
        #1;
        chk(name, 256'(collide), 256'(exp));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_board"}, 256'(board), 256'(0));
        chk({tag, "_lock_ready"}, 256'(lock_ready), 256'(1));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_clear_done"}, 256'(clear_done), 256'(0));
        chk({tag, "_lines_total"}, 256'(lines_total), 256'(0));
        chk({tag, "_sat_total"}, 256'(s_lines_total), 256'(16'hFFFE));
    endtask

    initial begin
        logic [NB-1:0] exp_b;
        exp_t e;
        int acc;
        int n;

        reset = 1'b1; lock_valid = 1'b0; px = '0; py = '0; pm = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        chk("reset_lines_cleared", 256'(lines_cleared), 256'(0));
        chk("reset_top_out", 256'(top_out), 256'(0));
        reset = 1'b0;

        // Test 1: single piece on the bottom row
        exp_b = '0;
        exp_b = rect(exp_b, 0, 23, 4, 1);
        lock_req(10'd0, 10'd460, 16'h000F, exp_b, 0, 0, 16'hFFFE, 1'b1);
        wait_done();
        chk("t1_slice", 256'(board[233:230]), 256'(4'hF));
        probe("coll_overlap", 10'd0, 10'd460, 16'h0001, 1'b1);
        probe("coll_row24_trunc", 10'd19, 10'd479, 16'h0010, 1'b1);
        probe("coll_free", 10'd40, 10'd440, 16'h000F, 1'b0);
        probe("coll_y480", 10'd0, 10'd480, 16'h0001, 1'b1);
        probe("coll_col10", 10'd180, 10'd0, 16'h0002, 1'b1);
        probe("coll_empty_mask", 10'd180, 10'd0, 16'h0000, 1'b0);

        // Test 2: one row cleared, row above drops down
        exp_b = rect(exp_b, 4, 23, 2, 1);
        lock_req(10'd80, 10'd460, 16'h0003, exp_b, 0, 0, 16'hFFFE, 1'b1);
        wait_done();
        exp_b = rect(exp_b, 9, 22, 1, 1);
        lock_req(10'd180, 10'd440, 16'h0001, exp_b, 0, 0, 16'hFFFE, 1'b1);
        wait_done();
        exp_b = '0;
        exp_b[239] = 1'b1;
        lock_req(10'd120, 10'd460, 16'h000F, exp_b, 1, 1, 16'hFFFF, 1'b1);
        wait_done();

        // Test 3: four rows at once after a fresh reset
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_state("rst2");
        @(negedge clk);
        reset = 1'b0;
        exp_b = '0;
        exp_b = rect(exp_b, 0, 20, 4, 4);
        lock_req(10'd0, 10'd400, 16'hFFFF, exp_b, 0, 0, 16'hFFFE, 1'b1);
        wait_done();
        exp_b = rect(exp_b, 4, 20, 4, 4);
        lock_req(10'd80, 10'd400, 16'hFFFF, exp_b, 0, 0, 16'hFFFE, 1'b1);
        wait_done();
        exp_b = rect(exp_b, 8, 20, 1, 4);
        lock_req(10'd160, 10'd400, 16'h1111, exp_b, 0, 0, 16'hFFFE, 1'b1);
        wait_done();
        probe("t3_coll_col9", 10'd180, 10'd400, 16'h1111, 1'b0);
        probe("t3_coll_col8", 10'd160, 10'd400, 16'h1111, 1'b1);
        exp_b = '0;
        lock_req(10'd180, 10'd400, 16'h1111, exp_b, 4, 4, 16'hFFFF, 1'b1);
        wait_done();
        chk("t3_board_zero", 256'(board), 256'(0));

        // Test 4: piece hanging off the right edge on row 0
        probe("t4_coll_edge", 10'd160, 10'd0, 16'h000F, 1'b1);
        exp_b = '0;
        exp_b[9:8] = 2'b11;
        lock_req(10'd160, 10'd0, 16'h000F, exp_b, 0, 4, 16'hFFFF, 1'b1);
        wait_done();
        chk("t4_top_out", 256'(top_out), 256'(1));

        // Test 5a: request held through busy; second piece only merges after IDLE
        @(negedge clk);
        px = 10'd0; py = 10'd300; pm = 16'h0001; lock_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        exp_b[150] = 1'b1;
        e.board = exp_b; e.lines = 0; e.total = 4; e.total_sat = 16'hFFFF; e.acc = cyc;
        sb.push_back(e);
        acc = cyc;
        px = 10'd20;
        @(negedge clk);
        chk("t5_busy", 256'(busy), 256'(1));
        chk("t5_ready_low", 256'(lock_ready), 256'(0));
        n = 0;
        while (!lock_ready && n < 100) begin
            if (board[151] !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL t5_early_merge: got 1 expected 0 at cycle %0d", cyc);
            end
            @(negedge clk);
            n++;
        end
        chk("t5_ready_wait", 256'(cyc - acc), 256'(25));
        @(posedge clk);
        #1;
        lock_valid = 1'b0;
        exp_b[151] = 1'b1;
        e.board = exp_b; e.lines = 0; e.total = 4; e.total_sat = 16'hFFFF; e.acc = cyc;
        sb.push_back(e);
        wait_done();

        // Test 5b: reset asserted while a row is being shifted
        exp_b = rect(exp_b, 0, 23, 4, 1);
        lock_req(10'd0, 10'd460, 16'h000F, exp_b, 0, 4, 16'hFFFF, 1'b1);
        wait_done();
        exp_b = rect(exp_b, 4, 23, 4, 1);
        lock_req(10'd80, 10'd460, 16'h000F, exp_b, 0, 4, 16'hFFFF, 1'b1);
        wait_done();
        lock_req(10'd160, 10'd460, 16'h0003, exp_b, 0, 0, 0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("t5_pre_reset_busy", 256'(busy), 256'(1));
        reset = 1'b1;
        #1;
        check_reset_state("midshift");
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("sb_empty", 256'(sb.size()), 256'(0));
        chk("final_board", 256'(board), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
